// File: rtl/msx_mapper_multi_if.sv
// Z80 cartridge-slot bus as seen by the mapper: address/data, strobes and readback.
interface msx_mapper_multi_if;
   logic [15:0] addr;
   logic [7:0]  cdin;
   logic [7:0]  cdout;
   logic        cdout_oe;
   logic        sltsl_n;
   logic        merq_n;
   logic        iorq_n;
   logic        m1_n;
   logic        rd_n;
   logic        wr_n;

   modport master (
      output addr, cdin, sltsl_n, merq_n, iorq_n, m1_n, rd_n, wr_n,
      input  cdout, cdout_oe
   );

   modport slave (
      input  addr, cdin, sltsl_n, merq_n, iorq_n, m1_n, rd_n, wr_n,
      output cdout, cdout_oe
   );
endinterface

// File: rtl/msx_mapper_multi.sv
// Multi-layout MSX cartridge mapper: bank-switch decode, SDRAM address translation,
// bank readback and RAM-mode control over I/O, with one commit per Z80 bus access.
module msx_mapper_multi #(
   parameter int                 ADDR_W    = 23,
   parameter int                 BANK_W    = 8,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = 23'h420000,
   parameter logic [7:0]         RAM_PORT  = 8'h8E,
   parameter logic [7:0]         RB_PORT   = 8'h8C
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   msx_mapper_multi_if.slave    bus,
   input  logic [2:0]           mapper_type,
   input  logic [BANK_W-1:0]    bank_mask,
   input  logic                 scc_enable,
   output logic                 cart_ena,
   output logic                 ram_ena,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 scc_sel
);

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   state_t            state;
   logic [BANK_W-1:0] bank_r [4];
   logic              scc_on;

   logic [1:0]        page;
   logic [1:0]        bank_idx;
   logic              bank_hit;
   logic              scc_hit;
   logic              commit;
   logic              scc_wr;
   logic              io_cyc;
   logic              bus_quiet;
   logic [7:0]        port;
   logic [BANK_W-1:0] bank_8k;
   logic [BANK_W-1:0] bank_16k;
   logic [ADDR_W-1:0] offset;

   assign page      = {bus.addr[15], bus.addr[13]};
   assign port      = bus.addr[7:0];
   assign cart_ena  = ~bus.sltsl_n & ~bus.merq_n & bus.iorq_n &
                      (bus.addr[15:14] == 2'b01 || bus.addr[15:14] == 2'b10);
   assign scc_sel   = scc_on & (mapper_type == 3'b001) & ~bus.sltsl_n & ~bus.merq_n &
                      bus.iorq_n & (bus.addr[15:11] == 5'b10011);
   assign scc_hit   = (mapper_type == 3'b001) & (bus.addr[15:11] == 5'b10010);
   assign commit    = cart_ena & ~bus.wr_n & bank_hit & ~ram_ena;
   assign scc_wr    = cart_ena & ~bus.wr_n & scc_hit;
   assign io_cyc    = ~bus.iorq_n & bus.m1_n;
   assign bus_quiet = bus.rd_n & bus.wr_n & bus.iorq_n & bus.merq_n;

   // NOTE: every variable assigned here gets a default first so no latch is inferred.
   always_comb begin
      bank_hit = 1'b0;
      bank_idx = page;
      case (mapper_type)
         3'b000: bank_hit = 1'b1;
         3'b001: bank_hit = (bus.addr[12:11] == 2'b10);
         3'b010: begin
            bank_hit = (bus.addr[15:11] == 5'b01100) || (bus.addr[15:11] == 5'b01110);
            bank_idx = {1'b0, bus.addr[12]};
         end
         3'b011: begin
            bank_hit = (bus.addr[15:13] == 3'b011);
            bank_idx = bus.addr[12:11];
         end
         default: bank_hit = 1'b0;
      endcase
   end

   // Translation is purely combinational, so a committed bank shows on the next access.
   always_comb begin
      bank_8k  = bank_r[page] & bank_mask;
      bank_16k = bank_r[{1'b0, bus.addr[15]}] & bank_mask;
      if (mapper_type[2])
         offset = ADDR_W'(bus.addr[14:0]) - ADDR_W'(15'h4000);
      else if (mapper_type == 3'b010)
         offset = ADDR_W'({bank_16k, bus.addr[13:0]});
      else
         offset = ADDR_W'({bank_8k, bus.addr[12:0]});
      mem_addr = BASE_ADDR + offset;
   end

   // NOTE: the four bank registers are reset individually (reg[i]=i); this is a
   // small flop file, not a RAM, so resetting it costs nothing and is required.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) bank_r[i] <= BANK_W'(i);
         ram_ena      <= 1'b0;
         scc_on       <= 1'b0;
         bus.cdout    <= 8'h00;
         bus.cdout_oe <= 1'b0;
         state        <= ST_IDLE;
      end else if (enable) begin
         case (state)
            ST_IDLE: begin
               if (commit || scc_wr) begin
                  if (commit) bank_r[bank_idx] <= bus.cdin[BANK_W-1:0];
                  if (scc_wr) scc_on <= (bus.cdin[5:0] == 6'h3F) & scc_enable;
                  state <= ST_HOLD;
               end else if (io_cyc) begin
                  if (port == RAM_PORT && !bus.rd_n)      ram_ena <= 1'b1;
                  else if (port == RAM_PORT && !bus.wr_n) ram_ena <= 1'b0;
                  if (port[7:2] == RB_PORT[7:2] && !bus.rd_n) begin
                     bus.cdout    <= 8'(bank_r[port[1:0]]);
                     bus.cdout_oe <= 1'b1;
                  end
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // Stay here until the Z80 releases every strobe: one commit per access.
               if (bus_quiet) begin
                  bus.cdout_oe <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msx_mapper_multi.sv
// Directed scoreboard bench for msx_mapper_multi: expectations queued at stimulus, checked at output.
module tb_msx_mapper_multi;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [2:0]  mapper_type;
   logic [7:0]  bank_mask;
   logic        scc_enable;
   logic        cart_ena;
   logic        ram_ena;
   logic [22:0] mem_addr;
   logic        scc_sel;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];

   msx_mapper_multi_if bus ();

   msx_mapper_multi dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .bus         (bus.slave),
      .mapper_type (mapper_type),
      .bank_mask   (bank_mask),
      .scc_enable  (scc_enable),
      .cart_ena    (cart_ena),
      .ram_ena     (ram_ena),
      .mem_addr    (mem_addr),
      .scc_sel     (scc_sel)
   );

   always #5 clk = ~clk;

   task automatic expect_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sb_q.size() == 0) begin
         bad++;
         $error("FAIL sb_empty: observed=%0h with no queued expectation", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.sltsl_n = 1'b1;
      bus.merq_n  = 1'b1;
      bus.iorq_n  = 1'b1;
      bus.m1_n    = 1'b1;
      bus.rd_n    = 1'b1;
      bus.wr_n    = 1'b1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus_idle();
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic mem_read(input logic [15:0] a, input logic [31:0] exp_addr,
                           input logic exp_scc, input string tag);
      expect_push(tag, exp_addr);
      expect_push({tag, "_scc"}, 32'(exp_scc));
      bus.addr    = a;
      bus.sltsl_n = 1'b0;
      bus.merq_n  = 1'b0;
      bus.rd_n    = 1'b0;
      #1;
      check(32'(mem_addr));
      check(32'(scc_sel));
      tick();
      bus_idle();
      tick();
   endtask

   task automatic mem_write(input logic [15:0] a, input logic [7:0] d, input int n);
      bus.addr    = a;
      bus.cdin    = d;
      bus.sltsl_n = 1'b0;
      bus.merq_n  = 1'b0;
      bus.wr_n    = 1'b0;
      repeat (n) tick();
      bus_idle();
      tick();
   endtask

   task automatic io_start(input logic [7:0] p, input logic is_wr);
      bus.addr   = {8'h00, p};
      bus.iorq_n = 1'b0;
      if (is_wr) bus.wr_n = 1'b0;
      else       bus.rd_n = 1'b0;
      tick();
   endtask

   task automatic io_end();
      bus_idle();
      tick();
   endtask

   initial begin
      enable      = 1'b1;
      mapper_type = 3'b000;
      bank_mask   = 8'hFF;
      scc_enable  = 1'b0;
      bus.addr    = 16'h0000;
      bus.cdin    = 8'h00;
      do_reset();

      // Reset state
      expect_push("rst_oe", 32'h0);    check(32'(bus.cdout_oe));
      expect_push("rst_cdout", 32'h0); check(32'(bus.cdout));
      expect_push("rst_ram", 32'h0);   check(32'(ram_ena));
      expect_push("rst_cart", 32'h0);  check(32'(cart_ena));

      // Konami: reset banks are 0..3
      mem_read(16'h4000, 32'h420000, 1'b0, "k_p0");
      mem_read(16'h6000, 32'h422000, 1'b0, "k_p1");
      mem_read(16'h8000, 32'h424000, 1'b0, "k_p2");
      mem_read(16'hA000, 32'h426000, 1'b0, "k_p3");

      // ASCII8: wr_n held low 4 cycles with data changing after the first; one commit only
      mapper_type = 3'b011;
      bus.addr    = 16'h6800;
      bus.cdin    = 8'h05;
      bus.sltsl_n = 1'b0;
      bus.merq_n  = 1'b0;
      bus.wr_n    = 1'b0;
      expect_push("a8_cart", 32'h1);
      #1 check(32'(cart_ena));
      tick();
      bus.cdin = 8'h06;
      repeat (3) tick();
      bus_idle();
      tick();
      mem_read(16'h6000, 32'h42A000, 1'b0, "a8_once");

      // ASCII16 with bank mask
      mapper_type = 3'b010;
      bank_mask   = 8'h03;
      mem_write(16'h7000, 8'h07, 2);
      mem_read(16'h8123, 32'h42C123, 1'b0, "a16_mask");
      mem_read(16'h4000, 32'h420000, 1'b0, "a16_p0");

      // Konami-SCC
      bank_mask   = 8'hFF;
      mapper_type = 3'b001;
      scc_enable  = 1'b1;
      mem_write(16'h9000, 8'h3F, 2);
      mem_read(16'h9800, 32'h49F800, 1'b1, "scc_on");
      mapper_type = 3'b000;
      mem_read(16'h9800, 32'h49F800, 1'b0, "scc_type0");
      mapper_type = 3'b001;
      mem_write(16'h9000, 8'h00, 2);
      mem_read(16'h9800, 32'h421800, 1'b0, "scc_off");

      // RAM mode suppresses bank writes
      do_reset();
      mapper_type = 3'b000;
      io_start(8'h8E, 1'b0);
      expect_push("ram_on", 32'h1); check(32'(ram_ena));
      io_end();
      mem_write(16'h6000, 8'h09, 2);
      mem_read(16'h6000, 32'h422000, 1'b0, "ram_nowr");
      io_start(8'h8D, 1'b0);
      expect_push("rb_reg1_rst", 32'h01); check(32'(bus.cdout));
      io_end();
      io_start(8'h8E, 1'b1);
      expect_push("ram_off", 32'h0); check(32'(ram_ena));
      io_end();

      // Bank readback and cdout_oe lifetime
      mem_write(16'h6000, 8'h12, 2);
      io_start(8'h8D, 1'b0);
      expect_push("rb_data", 32'h12); check(32'(bus.cdout));
      expect_push("rb_oe", 32'h1);    check(32'(bus.cdout_oe));
      tick();
      expect_push("rb_oe_hold", 32'h1); check(32'(bus.cdout_oe));
      io_end();
      expect_push("rb_oe_drop", 32'h0); check(32'(bus.cdout_oe));

      // Int-ack I/O is ignored
      bus.m1_n = 1'b0;
      io_start(8'h8E, 1'b0);
      expect_push("intack_ram", 32'h0); check(32'(ram_ena));
      io_end();

      // Reset in the middle of a readback
      io_start(8'h8D, 1'b0);
      expect_push("mid_oe", 32'h1); check(32'(bus.cdout_oe));
      reset_n = 1'b0;
      tick();
      expect_push("mid_rst_oe", 32'h0);    check(32'(bus.cdout_oe));
      expect_push("mid_rst_cdout", 32'h0); check(32'(bus.cdout));
      reset_n = 1'b1;
      io_end();

      // enable=0 blocks commits
      enable = 1'b0;
      mem_write(16'h8000, 8'h44, 3);
      enable = 1'b1;
      mem_read(16'h8000, 32'h424000, 1'b0, "en_off");

      // Plain 32K: no writes; type change keeps registers
      mapper_type = 3'b100;
      mem_write(16'h6000, 8'h33, 2);
      mem_read(16'h5123, 32'h421123, 1'b0, "plain");
      mapper_type = 3'b000;
      mem_read(16'h6000, 32'h422000, 1'b0, "plain_nowr");

      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $error("FAIL sb_left: observed=%0d expected=0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
